// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one port of a 512x8 synchronous block RAM between two masters.
// Optional locked-burst priority is enabled by defining RAMARB_LOCK_EN.
module ram_port_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  output logic          ram_rst,
  input  logic [DW-1:0] ram_do
);

  // Handshake: a master holds req (and its fields) until it sees gnt in the
  // same cycle; a read's data arrives as a one-cycle rvalid on the next cycle.

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_M0   = 2'd1,
    RD_M1   = 2'd2
  } rd_owner_t;

  rd_owner_t rd_owner, rd_owner_nxt;
  logic      last_winner;  // 0 = M0 won last, 1 = M1 won last
  logic      pick_m1;
  logic      lock_hold;

`ifdef RAMARB_LOCK_EN
  logic [7:0] lock_cnt;
  logic       win_lock;

  // The previous winner keeps a tie while it is mid-burst and still asserts req+lock.
  assign lock_hold = (lock_cnt != 8'd0) && (lock_cnt < 8'(MAX_LOCK)) &&
                     (last_winner ? (m1_req && m1_lock) : (m0_req && m0_lock));
  assign win_lock  = m1_gnt ? m1_lock : m0_lock;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_cnt <= 8'd0;
    end else if (!(m0_gnt || m1_gnt)) begin
      lock_cnt <= 8'd0;
    end else if (lock_cnt == 8'(MAX_LOCK)) begin
      lock_cnt <= 8'd0;
    end else if (win_lock) begin
      lock_cnt <= (lock_cnt != 8'd0 && m1_gnt == last_winner) ? lock_cnt + 8'd1 : 8'd1;
    end else begin
      lock_cnt <= 8'd0;
    end
  end
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

  always_comb begin
    pick_m1 = m1_req;
    if (m0_req && m1_req) begin
      pick_m1 = lock_hold ? last_winner : ~last_winner;
    end
    m0_gnt = RST_N && m0_req && !pick_m1;
    m1_gnt = RST_N && m1_req && pick_m1;
  end

  always_comb begin
    ram_en   = m0_gnt || m1_gnt;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (m1_gnt) begin
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_di   = m1_wdata;
    end else if (m0_gnt) begin
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_di   = m0_wdata;
    end
  end

  always_comb begin
    rd_owner_nxt = RD_NONE;
    if (m0_gnt && !m0_we) rd_owner_nxt = RD_M0;
    if (m1_gnt && !m1_we) rd_owner_nxt = RD_M1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_winner <= 1'b1;
      rd_owner    <= RD_NONE;
    end else begin
      if (m0_gnt || m1_gnt) last_winner <= m1_gnt;
      rd_owner <= rd_owner_nxt;
    end
  end

  assign m0_rvalid = (rd_owner == RD_M0);
  assign m1_rvalid = (rd_owner == RD_M1);
  assign m0_rdata  = ram_do;
  assign m1_rdata  = ram_do;
  assign ram_rst   = 1'b0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, rule-level reference model, per-cycle compare, directed tests.
module tb_ram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int MAX_LOCK = 3;
`ifdef RAMARB_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di, ram_do;

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_rst(ram_rst), .ram_do(ram_do)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
    if (a == 9'h005) return 8'hA5;
    if (a == 9'h010) return 8'h5A;
    return a[7:0] ^ 8'h5C;
  endfunction

  // block RAM stand-in: synchronous read, write commits at the edge
  logic [DW-1:0] mem [512];
  bit            mem_init = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] = preload(AW'(i));
      mem_init = 1'b1;
    end
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_di;
      else ram_do <= mem[ram_addr];
    end
  end

  // reference model
  logic [DW-1:0] exp_mem [512];
  logic [DW-1:0] exp_q [$];
  bit            m_init = 1'b0;
  bit            m_last, m_rv0, m_rv1;
`ifdef RAMARB_LOCK_EN
  int            m_run;
`endif

  function automatic logic [1:0] model_pick();
    if (!RST_N) return 2'b00;
    if (m0_req && !m1_req) return 2'b01;
    if (m1_req && !m0_req) return 2'b10;
    if (!m0_req && !m1_req) return 2'b00;
`ifdef RAMARB_LOCK_EN
    if (m_run > 0 && m_run < MAX_LOCK && (m_last ? m1_lock : m0_lock))
      return m_last ? 2'b10 : 2'b01;
`endif
    return m_last ? 2'b01 : 2'b10;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    logic [1:0] g;
    if (!m_init) begin
      for (int i = 0; i < 512; i++) exp_mem[i] = preload(AW'(i));
      m_init = 1'b1;
    end
    if (!RST_N) begin
      m_last <= 1'b1;
      m_rv0  <= 1'b0;
      m_rv1  <= 1'b0;
      exp_q.delete();
`ifdef RAMARB_LOCK_EN
      m_run  <= 0;
`endif
    end else begin
      g = model_pick();
      m_rv0 <= g[0] && !m0_we;
      m_rv1 <= g[1] && !m1_we;
      if (g != 2'b00) begin
        m_last <= g[1];
        if (g[1]) begin
          if (m1_we) exp_mem[m1_addr] = m1_wdata;
          else exp_q.push_back(exp_mem[m1_addr]);
        end else begin
          if (m0_we) exp_mem[m0_addr] = m0_wdata;
          else exp_q.push_back(exp_mem[m0_addr]);
        end
      end
`ifdef RAMARB_LOCK_EN
      if (g == 2'b00) m_run <= 0;
      else if (m_run >= MAX_LOCK) m_run <= 0;
      else if (g[1] ? m1_lock : m0_lock)
        m_run <= (m_run > 0 && g[1] == m_last) ? m_run + 1 : 1;
      else m_run <= 0;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / per-cycle compare
  always @(negedge CLK) begin
    logic [1:0]    g;
    logic [DW-1:0] d;
    g = model_pick();
    chk("m0_gnt", 32'(m0_gnt), 32'(g[0]));
    chk("m1_gnt", 32'(m1_gnt), 32'(g[1]));
    chk("ram_en", 32'(ram_en), 32'(|g));
    chk("ram_rst", 32'(ram_rst), 32'(1'b0));
    if (g != 2'b00) begin
      chk("ram_we", 32'(ram_we), 32'(g[1] ? m1_we : m0_we));
      chk("ram_addr", 32'(ram_addr), 32'(g[1] ? m1_addr : m0_addr));
      if (g[1] ? m1_we : m0_we) chk("ram_di", 32'(ram_di), 32'(g[1] ? m1_wdata : m0_wdata));
    end
    chk("m0_rvalid", 32'(m0_rvalid), 32'(m_rv0 && RST_N));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(m_rv1 && RST_N));
    if (m0_rvalid || m1_rvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rdata: rvalid with no read outstanding at %0t", $time);
      end else begin
        d = exp_q.pop_front();
        chk("rdata", 32'(m0_rvalid ? m0_rdata : m1_rdata), 32'(d));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  task automatic drive0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk;
  endtask

  task automatic drive1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk;
  endtask

  task automatic reset_pulse();
    RST_N = 0;
    #2;
    RST_N = 1;
  endtask

  initial begin
    RST_N = 0;
    idle();
    m0_req = 1;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);

    // single read from M0 after reset release
    tick();
    RST_N = 1;
    idle();
    drive0(0, 9'h005, 8'h00, 0);
    @(negedge CLK);
    chk("t1_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("t1_ram_addr", 32'(ram_addr), 32'h005);
    tick();
    m0_req = 0;
    @(negedge CLK);
    chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("t1_m0_rdata", 32'(m0_rdata), 32'hA5);
    chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // lone M1 read so that M0 owns the next tie
    tick();
    drive1(0, 9'h000, 8'h00, 0);
    tick();

    // contention: alternation, M0 reads pipelined behind its grants
    drive0(0, 9'h010, 8'h00, 0);
    drive1(1, 9'h020, 8'h3C, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t2_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
      chk("t2_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
      chk("t2_m0_rvalid", 32'(m0_rvalid), 32'(i % 2 == 1));
      if (i % 2 == 1) chk("t2_m0_rdata", 32'(m0_rdata), 32'h5A);
      tick();
    end
    idle();
    drive0(0, 9'h020, 8'h00, 0);
    @(negedge CLK);
    chk("t2_rb_gnt", 32'(m0_gnt), 32'd1);
    tick();
    m0_req = 0;
    @(negedge CLK);
    chk("t2_rb_rdata", 32'(m0_rdata), 32'h3C);

    // write then read at the top address
    tick();
    drive1(1, 9'h1FF, 8'h77, 0);
    @(negedge CLK);
    chk("t3_wr_gnt", 32'(m1_gnt), 32'd1);
    tick();
    drive1(0, 9'h1FF, 8'h00, 0);
    @(negedge CLK);
    chk("t3_rd_gnt", 32'(m1_gnt), 32'd1);
    tick();
    m1_req = 0;
    @(negedge CLK);
    chk("t3_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("t3_m1_rdata", 32'(m1_rdata), 32'h77);

    // reset while a read is in flight
    tick();
    drive0(0, 9'h005, 8'h00, 0);
    @(negedge CLK);
    chk("t4_m0_gnt", 32'(m0_gnt), 32'd1);
    tick();
    m0_req = 0;
    reset_pulse();
    @(negedge CLK);
    chk("t4_m0_rvalid_a", 32'(m0_rvalid), 32'd0);
    tick();
    @(negedge CLK);
    chk("t4_m0_rvalid_b", 32'(m0_rvalid), 32'd0);
    tick();
    drive0(0, 9'h010, 8'h00, 0);
    drive1(0, 9'h1FF, 8'h00, 0);
    @(negedge CLK);
    chk("t4_tie_m0", 32'(m0_gnt), 32'd1);
    chk("t4_tie_m1", 32'(m1_gnt), 32'd0);
    tick();
    m1_req = 0;  // loser withdraws without a grant
    drive0(0, 9'h011, 8'h00, 0);
    tick();

    // locking master vs continuous contender
    idle();
    reset_pulse();
    drive0(0, 9'h005, 8'h00, 1);
    drive1(0, 9'h010, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("t5_m0_gnt", 32'(m0_gnt), 32'(LOCK_BUILD ? (i % 4 != 3) : (i % 2 == 0)));
      chk("t5_m1_gnt", 32'(m1_gnt), 32'(LOCK_BUILD ? (i % 4 == 3) : (i % 2 == 1)));
      tick();
    end
    m0_lock = 0;
    repeat (4) tick();
    idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the 512x8 dual-port block RAM between two requesters.
  - M0: CPU data path.
  - M1: loader/DMA engine.
- Round-robin arbitration with single-cycle grant, then read-data return aligned to the RAM's one-cycle synchronous read latency.
- Sits between the requesters and the RAM port pins EN/WE/ADDR/DI/DO/RST; the other RAM port is untouched.

Parameters:
- AW, 9, address width (512 entries).
- DW, 8, data width.
- MAX_LOCK, 8, maximum consecutive grants to a locking master (used only with RAMARB_LOCK_EN); legal range 1..255.

Ports:
- CLK  in  1  rising-edge clock, shared with the RAM port.
- RST_N  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 access request; held until m0_gnt.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  AW  M0 address.
- m0_wdata  in  DW  M0 write data.
- m0_lock  in  1  M0 requests to keep the grant (feature-dependent).
- m0_gnt  out  1  M0 access accepted this cycle (combinational).
- m0_rvalid  out  1  M0 read data valid (registered).
- m0_rdata  out  DW  M0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as M0.
- ram_en  out  1  to RAM EN.
- ram_we  out  1  to RAM WE.
- ram_addr  out  AW  to RAM ADDR.
- ram_di  out  DW  to RAM DI.
- ram_rst  out  1  to RAM RST; constant 0.
- ram_do  in  DW  from RAM DO.

Behaviour:
- Reset (RST_N low, asynchronous):
  - m0_rvalid=m1_rvalid=0.
  - last_winner=1, so M0 wins the first tie.
  - rd_owner=none; lock_cnt=0.
  - Combinational outputs are 0 while reset is held.
- Arbitration per cycle, combinational from req inputs and registered state:
  - Only one req high: that master wins.
  - Both high: master != last_winner wins (round-robin).
  - Neither high: no grant; ram_en=0.
- Winner:
  - gnt=1 that cycle.
  - ram_en=1; ram_we, ram_addr, ram_di = winner's we/addr/wdata.
  - Loser's gnt=0; it must hold req and its fields stable.
- At the clock edge with a grant:
  - last_winner <= winner.
  - If read, rd_owner <= winner; otherwise rd_owner <= none.
- Read latency is 1 cycle:
  - The cycle after a read grant, {owner}_rvalid=1 for exactly one cycle.
  - {owner}_rdata = ram_do.
- rdata:
  - Both m*_rdata are wired to ram_do; they are meaningful only with rvalid.
  - Write grants produce no rvalid; completion is signalled by gnt alone.
- Back-to-back: a master may be granted every cycle when uncontested; reads pipeline at 1/cycle.
- Same-address write then read (next cycle): returns the new data, because the RAM commits the write at the first edge.
- req dropped without gnt: legal; no side effects.
- Reset asserted mid-read: the pending rvalid is cleared and never issued after reset release.
- No internal FIFO. Throughput is one access per cycle total.

Optional Feature:
- Macro: RAMARB_LOCK_EN.
- Defined:
  - A master granted with its lock=1 keeps priority on following cycles while req and lock stay high, even when the other master requests.
  - lock_cnt counts consecutive locked grants.
  - When lock_cnt reaches MAX_LOCK, the next tie goes to the other master; lock_cnt then resets to 0.
  - lock_cnt also clears when the locking master deasserts req or lock.
- Undefined:
  - m*_lock inputs are ignored; lock_cnt logic is absent; pure round-robin.

Test Plan:
- Reset release, M0 reads addr 0x005 holding 0xA5 -> m0_gnt same cycle; m0_rvalid=1 with m0_rdata=0xA5 one cycle later; m1_rvalid stays 0.
- Both request every cycle, M0 reads 0x010, M1 writes 0x020=0x3C -> grants alternate M0,M1,M0,M1; M0 rvalid only in the cycles following its grants; RAM[0x020]=0x3C.
- M1 writes 0x1FF=0x77 then reads 0x1FF on the next cycle -> m1_rvalid with 0x77.
- M0 read granted, RST_N pulsed low before the next edge -> m0_rvalid never asserts; after release, the first tie goes to M0.
- RAMARB_LOCK_EN, MAX_LOCK=3, M0 req+lock continuously, M1 req continuously -> grants M0,M0,M0,M1,M0,M0,M0,M1.
- Without RAMARB_LOCK_EN, same stimulus -> strict alternation M0,M1,M0,M1.
